// File: rtl/adc_acq_capture_pkg.sv
// Shared constants for the ADC capture block: one-hot FSM states and default widths.
package adc_acq_capture_pkg;
  localparam int ADC_DATA_WIDTH = 14;
  localparam int ADDR_WIDTH     = 12;
  localparam int ECHO_CNT_WIDTH = 16;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE  = 4'b0001;
  localparam state_t S_ARMED = 4'b0010;
  localparam state_t S_CAPT  = 4'b0100;
  localparam state_t S_DONE  = 4'b1000;
endpackage

// File: rtl/adc_acq_capture_if.sv
// Host/ADC-side bundle of the capture block; slave is the capture block, master drives it.
interface adc_acq_capture_if #(
    parameter int ADC_DATA_WIDTH = adc_acq_capture_pkg::ADC_DATA_WIDTH,
    parameter int ADDR_WIDTH     = adc_acq_capture_pkg::ADDR_WIDTH,
    parameter int ECHO_CNT_WIDTH = adc_acq_capture_pkg::ECHO_CNT_WIDTH
);
    logic                      arm;
    logic [ECHO_CNT_WIDTH-1:0] num_echoes;
    logic [ADC_DATA_WIDTH-1:0] adc_data;
    logic                      acq_en;
    logic                      busy;
    logic                      capt_done;
    logic                      overflow;
    logic [ADDR_WIDTH:0]       sample_cnt;
    logic [ECHO_CNT_WIDTH-1:0] echo_cnt;
    logic [ADDR_WIDTH-1:0]     rd_addr;
    logic [ADC_DATA_WIDTH-1:0] rd_data;

    modport slave (
        input  arm, num_echoes, adc_data, acq_en, rd_addr,
        output busy, capt_done, overflow, sample_cnt, echo_cnt, rd_data
    );

    modport master (
        output arm, num_echoes, adc_data, acq_en, rd_addr,
        input  busy, capt_done, overflow, sample_cnt, echo_cnt, rd_data
    );
endinterface

// File: rtl/adc_acq_ram.sv
// Simple dual-port sample buffer: one write port, one registered read-first read port.
module adc_acq_ram #(
    parameter int DATA_WIDTH = 14,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);
    logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rd_q;

    // Array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rd_q <= '0;
        else         rd_q <= mem_q[raddr_i];
    end

    assign rd_data_o = rd_q;
endmodule

// File: rtl/adc_acq_capture.sv
// Captures ADC samples inside ACQ_EN windows into a buffer, appending echoes until
// the programmed echo count is reached or the buffer fills.
module adc_acq_capture #(
    parameter int ADC_DATA_WIDTH = adc_acq_capture_pkg::ADC_DATA_WIDTH,
    parameter int ADDR_WIDTH     = adc_acq_capture_pkg::ADDR_WIDTH,
    parameter int ECHO_CNT_WIDTH = adc_acq_capture_pkg::ECHO_CNT_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    adc_acq_capture_if.slave         bus
);
    import adc_acq_capture_pkg::*;

    localparam logic [ADDR_WIDTH:0]       CNT_ONE  = 1;
    localparam logic [ECHO_CNT_WIDTH-1:0] ECHO_ONE = 1;

    logic                      en_q, en_prev_q;
    logic [ADC_DATA_WIDTH-1:0] dat_q;
    state_t                    state_q, state_d;
    logic [ADDR_WIDTH:0]       cnt_q;
    logic [ECHO_CNT_WIDTH-1:0] echo_q, num_q;
    logic                      ovf_q;

    logic in_capt, full, fall, we, echo_hit, echo_max;
    logic busy, capt_done;

    assign in_capt  = (state_q == S_CAPT);
    assign full     = cnt_q[ADDR_WIDTH];
    assign fall     = en_prev_q & ~en_q;
    assign echo_max = &echo_q;
    assign echo_hit = (num_q != '0) && ((echo_q + ECHO_ONE) == num_q);
    assign we       = in_capt & en_q & ~full & ~bus.arm;

    // Input stage; en_prev_q gives the previous EN_D for falling-edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q      <= 1'b0;
            en_prev_q <= 1'b0;
            dat_q     <= '0;
        end else begin
            en_q      <= bus.acq_en;
            en_prev_q <= en_q;
            dat_q     <= bus.adc_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.arm) begin
            state_d = S_ARMED;
        end else begin
            unique case (state_q)
                S_IDLE:  state_d = S_IDLE;
                // Only start on a low EN_D so a window already running is skipped whole.
                S_ARMED: if (!en_q) state_d = S_CAPT;
                S_CAPT:  if (fall && (echo_hit || full)) state_d = S_DONE;
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = 1'b0;
        capt_done = 1'b0;
        unique case (state_q)
            S_ARMED, S_CAPT: busy      = 1'b1;
            S_DONE:          capt_done = 1'b1;
            default:         ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            echo_q <= '0;
            num_q  <= '0;
            ovf_q  <= 1'b0;
        end else if (bus.arm) begin
            cnt_q  <= '0;
            echo_q <= '0;
            num_q  <= bus.num_echoes;
            ovf_q  <= 1'b0;
        end else if (in_capt) begin
            if (we)                cnt_q  <= cnt_q + CNT_ONE;
            if (en_q && full)      ovf_q  <= 1'b1;
            if (fall && !echo_max) echo_q <= echo_q + ECHO_ONE;
        end
    end

    adc_acq_ram #(
        .DATA_WIDTH (ADC_DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .we_i      (we),
        .waddr_i   (cnt_q[ADDR_WIDTH-1:0]),
        .wdata_i   (dat_q),
        .raddr_i   (bus.rd_addr),
        .rd_data_o (bus.rd_data)
    );

    assign bus.busy       = busy;
    assign bus.capt_done  = capt_done;
    assign bus.overflow   = ovf_q;
    assign bus.sample_cnt = cnt_q;
    assign bus.echo_cnt   = echo_q;
endmodule

// File: tb/tb_adc_acq_capture.sv
// Randomized + directed bench for adc_acq_capture against a window-level capture model.
module tb_adc_acq_capture;
    localparam int DW    = 14;
    localparam int AW    = 4;
    localparam int EW    = 16;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adc_acq_capture_if #(.ADC_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ECHO_CNT_WIDTH(EW)) bus ();

    adc_acq_capture #(.ADC_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ECHO_CNT_WIDTH(EW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    // Window-level reference: contents, counts and flags of the current capture.
    int m_mem [DEPTH];
    int m_cnt, m_echo, m_n;
    bit m_ovf, m_done;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input int n);
        bus.num_echoes = EW'(n);
        bus.arm        = 1'b1;
        tick();
        bus.arm = 1'b0;
        m_n = n; m_cnt = 0; m_echo = 0; m_ovf = 0; m_done = 0;
    endtask

    // Drives one full window then one low cycle, and folds it into the model.
    task automatic send_window(input int len, input bit rnd, input int base);
        int d;
        bit skip;
        skip = m_done;
        for (int i = 0; i < len; i++) begin
            d = rnd ? int'($urandom_range(0, (1 << DW) - 1)) : base + i;
            bus.acq_en   = 1'b1;
            bus.adc_data = DW'(d);
            tick();
            if (!skip) begin
                if (m_cnt < DEPTH) begin m_mem[m_cnt] = d; m_cnt++; end
                else m_ovf = 1;
            end
        end
        bus.acq_en = 1'b0;
        tick();
        if (!skip) begin
            if (m_echo < (1 << EW) - 1) m_echo++;
            if ((m_n != 0 && m_echo == m_n) || m_cnt == DEPTH) m_done = 1;
        end
    endtask

    task automatic check_state(input string t);
        chk({t, ".cnt"},  64'(bus.sample_cnt), 64'(m_cnt));
        chk({t, ".echo"}, 64'(bus.echo_cnt),   64'(m_echo));
        chk({t, ".ovf"},  64'(bus.overflow),   64'(m_ovf));
        chk({t, ".done"}, 64'(bus.capt_done),  64'(m_done));
        chk({t, ".busy"}, 64'(bus.busy),       64'(!m_done));
        for (int a = 0; a < m_cnt; a++) begin
            bus.rd_addr = AW'(a);
            tick();
            chk({t, ".rd"}, 64'(bus.rd_data), 64'(m_mem[a]));
        end
    endtask

    task automatic check_reset_vals(input string t);
        chk({t, ".busy"}, 64'(bus.busy), 0);
        chk({t, ".done"}, 64'(bus.capt_done), 0);
        chk({t, ".ovf"},  64'(bus.overflow), 0);
        chk({t, ".cnt"},  64'(bus.sample_cnt), 0);
        chk({t, ".echo"}, 64'(bus.echo_cnt), 0);
        chk({t, ".rd"},   64'(bus.rd_data), 0);
    endtask

    initial begin
        bus.arm = 1'b0; bus.num_echoes = '0; bus.adc_data = '0;
        bus.acq_en = 1'b0; bus.rd_addr = '0;
        tick(); tick();
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // Single window, one echo.
        do_arm(1);
        send_window(8, 0, 1);
        tick();
        check_state("win1");

        // Three appended echoes; DONE one cycle after the last fall is registered.
        do_arm(3);
        send_window(5, 0, 10);
        tick();
        send_window(5, 0, 15);
        send_window(5, 0, 20);
        chk("append.done_early", 64'(bus.capt_done), 0);
        tick();
        chk("append.done_rise", 64'(bus.capt_done), 1);
        check_state("append");

        // Arm four cycles into a running window: that window is skipped whole.
        for (int i = 0; i < 10; i++) begin
            bus.acq_en   = 1'b1;
            bus.adc_data = DW'(100 + i);
            if (i == 4) begin bus.num_echoes = EW'(1); bus.arm = 1'b1; end
            tick();
            if (i == 4) begin
                bus.arm = 1'b0;
                m_n = 1; m_cnt = 0; m_echo = 0; m_ovf = 0; m_done = 0;
            end
        end
        bus.acq_en = 1'b0;
        tick();
        send_window(6, 0, 200);
        tick();
        check_state("midarm");

        // Overflow with unlimited echoes: 20 samples into a 16-deep buffer.
        do_arm(0);
        send_window(20, 0, 1);
        tick();
        check_state("ovf");
        bus.rd_addr = AW'(15);
        tick();
        chk("ovf.addr15", 64'(bus.rd_data), 16);

        // Re-arm from DONE clears everything on the next cycle.
        do_arm(2);
        chk("rearm.ovf",  64'(bus.overflow), 0);
        chk("rearm.done", 64'(bus.capt_done), 0);
        chk("rearm.cnt",  64'(bus.sample_cnt), 0);
        chk("rearm.echo", 64'(bus.echo_cnt), 0);
        chk("rearm.busy", 64'(bus.busy), 1);

        // Reset mid-window, then a normal capture.
        for (int i = 0; i < 3; i++) begin
            bus.acq_en = 1'b1; bus.adc_data = DW'(300 + i);
            tick();
        end
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        bus.acq_en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        do_arm(1);
        send_window(4, 1, 0);
        tick();
        check_state("post_rst");

        // Randomized captures.
        for (int it = 0; it < 12; it++) begin
            int nw;
            do_arm(int'($urandom_range(0, 4)));
            nw = int'($urandom_range(1, 6));
            for (int w = 0; w < nw; w++) begin
                send_window(int'($urandom_range(1, 8)), 1, 0);
                repeat (int'($urandom_range(0, 2))) tick();
            end
            tick();
            check_state($sformatf("rnd%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
